dir_deser: RTL

- Serial-to-parallel deserializer. It is the receive-side counterpart of the bit-direction packing logic in the direction systest.
- Collects SIZE serial bits under a valid/ready handshake and assembles one word. Presents the word on a descending-range port, an ascending-range port, a bit-reversed port and a concatenated port.
- Lives in the direction systest suite so the toolkit's range, concatenation and sequential handling can be exercised on one block.

---
 rtl/dir_deser_pkg.sv | 14 +
 rtl/dir_deser_if.sv | 26 ++
 rtl/dir_deser_bit_rev.sv | 11 +
 rtl/dir_deser.sv | 91 +++++++++
 4 files changed

// File: rtl/dir_deser_pkg.sv
// Shared definitions for the direction deserializer: counter sizing and FSM state encoding.
package dir_pkg;

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_width(input int size);
    return (size <= 2) ? 1 : $clog2(size);
  endfunction

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/dir_deser_if.sv
// Serial input and parallel word output bundle for the direction deserializer.
interface dir_deser_if #(
  parameter int SIZE = 4
);
  logic              in_bit;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [SIZE-1:0]   out_desc;
  logic [0:SIZE-1]   out_asc;
  logic [SIZE-1:0]   out_rev;
  logic [2*SIZE-1:0] out_cat;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;

  modport slave (
    input  in_bit, in_valid, in_last, out_ready,
    output in_ready, out_desc, out_asc, out_rev, out_cat, out_valid, frame_err
  );

  modport master (
    output in_bit, in_valid, in_last, out_ready,
    input  in_ready, out_desc, out_asc, out_rev, out_cat, out_valid, frame_err
  );
endinterface

// File: rtl/dir_deser_bit_rev.sv
// Purely combinational bit-order reversal; shared with the serializer side.
module bit_rev #(
  parameter int W = 4
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  for (genvar i = 0; i < W; i++) begin : g_rev
    assign dout[i] = din[W-1-i];
  end
endmodule

// File: rtl/dir_deser.sv
// Serial-to-parallel deserializer: collects SIZE bits per framed word and
// presents the word in descending, ascending, reversed and concatenated form.
module dir_deser
  import dir_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  dir_deser_if.slave bus
);
  localparam int              CNT_W    = cnt_width(SIZE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

  if (SIZE < 2 || SIZE > 64) begin : g_size_check
    $error("dir_deser: SIZE must be within 2..64");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SIZE-1:0]  sr;
  logic [SIZE-1:0]  sr_next;
  logic [SIZE-1:0]  word;
  logic [SIZE-1:0]  word_rev;
  logic             frame_err;
  logic             out_valid;
  logic             accept;
  logic             at_last;
  logic             good_word;
  logic             bad_frame;

  assign out_valid    = (state == ST_HOLD);
  assign bus.in_ready = !out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign at_last      = (cnt == LAST_CNT);
  assign good_word    = accept && bus.in_last && at_last;
  // A frame is bad when in_last and the final-slot position disagree.
  assign bad_frame    = accept && (bus.in_last != at_last);

  if (MSB_FIRST) begin : g_msb_first
    assign sr_next = {sr[SIZE-2:0], bus.in_bit};
  end else begin : g_lsb_first
    assign sr_next = {bus.in_bit, sr[SIZE-1:1]};
  end

  // NOTE: state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_COLLECT;
      cnt       <= '0;
      sr        <= '0;
      word      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad_frame;

      if (accept) begin
        if (good_word || bad_frame) begin
          cnt <= '0;
          sr  <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
          sr  <= sr_next;
        end
      end

      // A word completing on the consume edge reloads with no bubble.
      if (good_word) begin
        word  <= sr_next;
        state <= ST_HOLD;
      end else if (out_valid && bus.out_ready) begin
        state <= ST_COLLECT;
      end
    end
  end

  bit_rev #(.W(SIZE)) u_bit_rev (
    .din  (word),
    .dout (word_rev)
  );

  assign bus.out_desc  = word;
  assign bus.out_asc   = word;
  assign bus.out_rev   = word_rev;
  assign bus.out_cat   = {word, word_rev};
  assign bus.out_valid = out_valid;
  assign bus.frame_err = frame_err;

endmodule
